spi_xfer_sequencer: RTL
=======================

Name: spi_xfer_sequencer

Overview:
- FSM that sequences the 8-bit SPI shift register and address/data memory strobes for one SPI slave transaction.
- Frame: 7-bit address MSB-first, then 1 R/W bit (1 = read), then 8 data bits.
- Drives shift-register mode and shift enable, address latch and memory write enables, and the MISO output enable.
- Sits between the SCLK edge detectors / CS synchronizer and the shift register, address latch and data memory.

Parameters:
ADDR_W, 7, address bits preceding the R/W bit
DATA_W, 8, data bits per transfer; must equal shift-register width
CNT_W, 4, bit-counter width; must hold max(ADDR_W+1, DATA_W)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cs_n  input  1  synchronized chip select, active low
sclk_posedge  input  1  one-clk strobe, SCLK rising edge
sclk_negedge  input  1  one-clk strobe, SCLK falling edge
rw_bit  input  1  shift-register parallelOut[0]; holds the R/W bit after the 8th header shift
sr_mode  output  2  shift-register mode: 00 hold, 01 right, 10 left, 11 parallel load
sr_shift_en  output  1  shift-register update enable, the serialClkposedge input
addr_we  output  1  address latch write enable, one clk
dm_we  output  1  data memory write enable, one clk
miso_oe  output  1  MISO tri-state buffer enable
busy  output  1  high in every state except IDLE
xfer_done  output  1  registered one-clk pulse, transfer completed
err_abort  output  1  registered one-clk pulse, CS deasserted mid-transfer

Behaviour:
- Reset (rst_n low, async): state IDLE, bit counter 0, sr_mode 00, all other outputs 0.
- sr_mode and sr_shift_en are combinational from state and strobes, so a shift lands on the same clk as the strobe. All other outputs are Moore or registered.
- IDLE: cs_n low -> GET_ADDR, counter cleared. A strobe arriving in the same clk is ignored.
- GET_ADDR: sr_mode 10 (left). sr_shift_en = sclk_posedge. Counter increments per posedge. On the posedge that brings the counter to ADDR_W+1 -> LATCH_ADDR.
- LATCH_ADDR (1 clk): addr_we=1, sr_mode 00, rw_bit sampled. rw_bit=1 -> READ_LOAD, else WRITE_SHIFT. Counter cleared.
- READ_LOAD (1 clk): sr_mode 11, sr_shift_en=1, miso_oe=1 -> READ_SHIFT. Data MSB is on serialOut before the next SCLK rise.
- READ_SHIFT: miso_oe=1, sr_mode 10, sr_shift_en = sclk_negedge. Counter increments per negedge. The DATA_W-th negedge -> DONE, and xfer_done pulses the next clk.
- WRITE_SHIFT: sr_mode 10, sr_shift_en = sclk_posedge. The DATA_W-th posedge -> WRITE_COMMIT.
- WRITE_COMMIT (1 clk): dm_we=1 -> DONE. xfer_done pulses the next clk.
- DONE: sr_mode 00, miso_oe=0. Strobes are ignored. cs_n high -> IDLE. Extra SCLK activity never starts a second frame until CS toggles.
- Abort: cs_n high in GET_ADDR, LATCH_ADDR, READ_LOAD, READ_SHIFT or WRITE_SHIFT has priority over all transitions.
  - Next state IDLE.
  - That clk: sr_shift_en=0, addr_we=0, dm_we=0.
  - err_abort pulses the next clk. Counter cleared.
- WRITE_COMMIT is not abortable: dm_we still asserts, then the FSM goes to IDLE if cs_n is high, else to DONE.
- Simultaneous sclk_posedge and sclk_negedge: only the strobe relevant to the current state acts; the other is ignored.
- Counter saturates and never wraps: strobes beyond the terminal count are impossible by the transitions above.
- xfer_done and err_abort are never high together and never high in consecutive clks for the same frame.

Test Plan:
- Reset mid-GET_ADDR after 3 posedges -> immediately: sr_mode=00, busy=0, all enables 0; after release a full frame works normally.
- Write: cs_n low, header 0x2A+W (bits 0101010,0), data 0xC3 on 16 posedges -> one addr_we pulse after posedge 8; 8 sr_shift_en pulses aligned to posedges 9-16; dm_we one clk after posedge 16; xfer_done next clk; no miso_oe.
- Read: header 0x15+R, then 8 negedges -> addr_we once; READ_LOAD gives sr_mode=11 for exactly 1 clk; miso_oe high from READ_LOAD until after negedge 8; exactly 8 negedge-aligned shifts; xfer_done=1 once; dm_we never asserted.
- Abort: cs_n high after 5 data posedges of a write -> dm_we never asserted; err_abort pulses once; busy=0 one clk later; the next full frame completes correctly.
- cs_n high in the same clk as WRITE_COMMIT -> dm_we=1 for 1 clk, xfer_done=1, err_abort=0, state IDLE.
- After DONE, 4 extra posedges with cs_n low -> no sr_shift_en, addr_we or dm_we activity; cs_n high -> IDLE.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// SPI slave transaction sequencer.
// Frame: ADDR_W address bits MSB-first, one R/W bit (1 = read), then DATA_W data bits.
// Drives the shift register, address latch, data memory write and the MISO enable.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// IDLE         | CS high, waiting for a frame
// GET_ADDR     | shifting the address + R/W header on SCLK rising edges
// LATCH_ADDR   | one clk: latch the address, branch on the R/W bit
// READ_LOAD    | one clk: parallel-load read data, MSB appears on serialOut
// READ_SHIFT   | shifting read data out on SCLK falling edges
// WRITE_SHIFT  | shifting write data in on SCLK rising edges
// WRITE_COMMIT | one clk: write the shifted data to memory (not abortable)
// DONE         | frame finished, waiting for CS to go high
module spi_xfer_sequencer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sclk_posedge,
    input  logic       sclk_negedge,
    input  logic       rw_bit,
    output logic [1:0] sr_mode,
    output logic       sr_shift_en,
    output logic       addr_we,
    output logic       dm_we,
    output logic       miso_oe,
    output logic       busy,
    output logic       xfer_done,
    output logic       err_abort
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_LATCH_ADDR,
        ST_READ_LOAD,
        ST_READ_SHIFT,
        ST_WRITE_SHIFT,
        ST_WRITE_COMMIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Terminal counts are compared against the value before the increment.
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             done_set, abort_set, abort_cond;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // CS loss is an abort in every state that has not yet committed data.
    assign abort_cond = cs_n && (state == ST_GET_ADDR   || state == ST_LATCH_ADDR ||
                                 state == ST_READ_LOAD  || state == ST_READ_SHIFT ||
                                 state == ST_WRITE_SHIFT);

    // Next-state, counter and output decode; abort overrides the per-state result.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sr_mode     = MODE_HOLD;
        sr_shift_en = 1'b0;
        addr_we     = 1'b0;
        dm_we       = 1'b0;
        miso_oe     = 1'b0;
        busy        = (state != ST_IDLE);
        done_set    = 1'b0;
        abort_set   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!cs_n) begin
                    state_nxt = ST_GET_ADDR;
                    cnt_nxt   = '0;
                end
            end
            ST_GET_ADDR: begin
                sr_mode = MODE_LEFT;
                if (sclk_posedge) begin
                    sr_shift_en = 1'b1;
                    cnt_nxt     = cnt_inc;
                    if (cnt == HDR_LAST) state_nxt = ST_LATCH_ADDR;
                end
            end
            ST_LATCH_ADDR: begin
                addr_we   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = rw_bit ? ST_READ_LOAD : ST_WRITE_SHIFT;
            end
            ST_READ_LOAD: begin
                sr_mode     = MODE_LOAD;
                sr_shift_en = 1'b1;
                miso_oe     = 1'b1;
                state_nxt   = ST_READ_SHIFT;
            end
            ST_READ_SHIFT: begin
                sr_mode = MODE_LEFT;
                miso_oe = 1'b1;
                if (sclk_negedge) begin
                    sr_shift_en = 1'b1;
                    cnt_nxt     = cnt_inc;
                    if (cnt == DATA_LAST) begin
                        state_nxt = ST_DONE;
                        cnt_nxt   = '0;
                        done_set  = 1'b1;
                    end
                end
            end
            ST_WRITE_SHIFT: begin
                sr_mode = MODE_LEFT;
                if (sclk_posedge) begin
                    sr_shift_en = 1'b1;
                    cnt_nxt     = cnt_inc;
                    if (cnt == DATA_LAST) begin
                        state_nxt = ST_WRITE_COMMIT;
                        cnt_nxt   = '0;
                    end
                end
            end
            ST_WRITE_COMMIT: begin
                dm_we     = 1'b1;
                done_set  = 1'b1;
                state_nxt = cs_n ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (cs_n) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (abort_cond) begin
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
            sr_shift_en = 1'b0;
            addr_we     = 1'b0;
            dm_we       = 1'b0;
            done_set    = 1'b0;
            abort_set   = 1'b1;
        end
    end

    // State, bit counter and the registered completion/abort pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            xfer_done <= 1'b0;
            err_abort <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            xfer_done <= done_set;
            err_abort <= abort_set;
        end
    end

endmodule
